// File: rtl/twin_reg_pkg.sv
// rtl/twin_reg_pkg.sv - state encoding and byte-order constants shared with twin-register capture logic
package twin_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } unload_state_e;

  localparam bit ORDER_D1_FIRST = 1'b0;
  localparam bit ORDER_D2_FIRST = 1'b1;

endpackage

// File: rtl/twin_reg_unloader_if.sv
// rtl/twin_reg_unloader_if.sv - pair-in / byte-out handshake bundle for the twin register unloader
interface twin_reg_unloader_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_d1;
  logic [WIDTH-1:0] in_d2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_last;
  logic [CNT_W-1:0] pair_cnt;

  // slave is the unloader's view; master is the surrounding producer/consumer.
  modport slave (
    input  in_valid, in_d1, in_d2, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last, pair_cnt
  );

  modport master (
    output in_valid, in_d1, in_d2, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last, pair_cnt
  );

endinterface

// File: rtl/twin_reg_unloader.sv
// rtl/twin_reg_unloader.sv - streams a captured (d1,d2) byte pair out as two beats, one pair per 2 clk
module twin_reg_unloader
  import twin_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit ORDER = ORDER_D1_FIRST,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  twin_reg_unloader_if.slave  bus
);

  unload_state_e    state_q, state_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [WIDTH-1:0] d2_q, d2_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic load_pair;

  // A new pair may enter while the second beat of the previous one leaves, giving no bubble.
  assign in_ready = !rst && !clr &&
                    ((state_q == IDLE) || ((state_q == BEAT2) && bus.out_ready));
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = valid_q && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    load_pair = 1'b0;

    if (clr) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          load_pair = in_fire;
        end
        BEAT1: begin
          if (out_fire) begin
            state_d = BEAT2;
            data_d  = ORDER ? d1_q : d2_q;
            sel_d   = ~ORDER;
            last_d  = 1'b1;
          end
        end
        BEAT2: begin
          if (out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (in_fire) begin
              load_pair = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      endcase

      if (load_pair) begin
        state_d = BEAT1;
        d1_d    = bus.in_d1;
        d2_d    = bus.in_d2;
        data_d  = ORDER ? bus.in_d2 : bus.in_d1;
        valid_d = 1'b1;
        sel_d   = ORDER;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d1_q    <= '0;
      d2_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = last_q;
  assign bus.pair_cnt  = cnt_q;

endmodule

// File: tb/tb_twin_reg_unloader.sv
// tb/tb_twin_reg_unloader.sv - directed bench: D1-first, D2-first and 2-bit-counter unloaders on shared stimulus
module tb_twin_reg_unloader;
  import twin_reg_pkg::*;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_d1;
  logic [7:0] in_d2;

  int checks = 0;
  int errors = 0;

  twin_reg_unloader_if #(.WIDTH(8), .CNT_W(8)) ifa ();
  twin_reg_unloader_if #(.WIDTH(8), .CNT_W(8)) ifb ();
  twin_reg_unloader_if #(.WIDTH(8), .CNT_W(2)) ifc ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_d1     = in_d1;
  assign ifa.in_d2     = in_d2;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_d1     = in_d1;
  assign ifb.in_d2     = in_d2;
  assign ifb.out_ready = out_ready;
  assign ifc.in_valid  = in_valid;
  assign ifc.in_d1     = in_d1;
  assign ifc.in_d2     = in_d2;
  assign ifc.out_ready = out_ready;

  twin_reg_unloader #(.WIDTH(8), .ORDER(ORDER_D1_FIRST), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .bus(ifa.slave)
  );
  twin_reg_unloader #(.WIDTH(8), .ORDER(ORDER_D2_FIRST), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .bus(ifb.slave)
  );
  twin_reg_unloader #(.WIDTH(8), .ORDER(ORDER_D1_FIRST), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .bus(ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after a posedge with all units idle and out_ready high; returns at a negedge.
  task automatic send_pairs(input int n, input logic [7:0] base);
    logic [31:0] d1v;
    logic [31:0] d2v;
    in_valid = 1'b1;
    in_d1    = base;
    in_d2    = base + 8'd1;
    for (int k = 0; k < 2 * n; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 0) begin
        if (k / 2 + 1 < n) begin
          in_d1 = base + 8'(k + 2);
          in_d2 = base + 8'(k + 3);
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      d1v = 32'(base + 8'(2 * (k / 2)));
      d2v = 32'(base + 8'(2 * (k / 2) + 1));
      check("bb_valid_a", 32'(ifa.out_valid), 1);
      check("bb_data_a", 32'(ifa.out_data), (k % 2 == 0) ? d1v : d2v);
      check("bb_data_b", 32'(ifb.out_data), (k % 2 == 0) ? d2v : d1v);
      check("bb_last_a", 32'(ifa.out_last), 32'(k % 2));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("bb_drain_valid", 32'(ifa.out_valid), 0);
  endtask

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_d1     = 8'h00;
    in_d2     = 8'h00;

    // reset state
    @(negedge clk);
    check("rst_in_ready", 32'(ifa.in_ready), 0);
    check("rst_valid", 32'(ifa.out_valid), 0);
    check("rst_data", 32'(ifa.out_data), 0);
    check("rst_cnt", 32'(ifa.pair_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(ifa.in_ready), 1);

    // single pair, both orders
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_d1     = 8'hA5;
    in_d2     = 8'h3C;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("p1_valid_a", 32'(ifa.out_valid), 1);
    check("p1_data_a", 32'(ifa.out_data), 'hA5);
    check("p1_sel_a", 32'(ifa.out_sel), 0);
    check("p1_last_a", 32'(ifa.out_last), 0);
    check("p1_data_b", 32'(ifb.out_data), 'h3C);
    check("p1_sel_b", 32'(ifb.out_sel), 1);
    check("p1_last_b", 32'(ifb.out_last), 0);
    check("p1_in_ready_beat1", 32'(ifa.in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("p2_data_a", 32'(ifa.out_data), 'h3C);
    check("p2_sel_a", 32'(ifa.out_sel), 1);
    check("p2_last_a", 32'(ifa.out_last), 1);
    check("p2_data_b", 32'(ifb.out_data), 'hA5);
    check("p2_sel_b", 32'(ifb.out_sel), 0);
    check("p2_last_b", 32'(ifb.out_last), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("p3_valid_a", 32'(ifa.out_valid), 0);
    check("p3_last_a", 32'(ifa.out_last), 0);
    check("p3_data_kept_a", 32'(ifa.out_data), 'h3C);
    check("p3_cnt_a", 32'(ifa.pair_cnt), 1);

    // four back-to-back pairs
    @(posedge clk); #1;
    send_pairs(4, 8'h10);
    check("bb4_cnt_a", 32'(ifa.pair_cnt), 5);
    check("bb4_cnt_c", 32'(ifc.pair_cnt), 1);

    // consumer stalls in BEAT1; input changes must be ignored
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_d1     = 8'hA5;
    in_d2     = 8'h3C;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_d1 = 8'hFF;
    in_d2 = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data_a", 32'(ifa.out_data), 'hA5);
      check("stall_valid_a", 32'(ifa.out_valid), 1);
      check("stall_in_ready", 32'(ifa.in_ready), 0);
      check("stall_data_b", 32'(ifb.out_data), 'h3C);
      in_d1 = in_d1 - 8'd1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_beat2_a", 32'(ifa.out_data), 'h3C);
    check("stall_beat2_last", 32'(ifa.out_last), 1);
    check("stall_beat2_b", 32'(ifb.out_data), 'hA5);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_cnt_a", 32'(ifa.pair_cnt), 6);
    check("stall_cnt_c", 32'(ifc.pair_cnt), 2);
    check("stall_done_valid", 32'(ifa.out_valid), 0);

    // clear while the second beat is being taken
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_d1    = 8'h12;
    in_d2    = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 32'(ifa.in_ready), 0);
    check("clr_pre_last", 32'(ifa.out_last), 1);
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_valid", 32'(ifa.out_valid), 0);
    check("clr_last", 32'(ifa.out_last), 0);
    check("clr_cnt_a", 32'(ifa.pair_cnt), 0);
    check("clr_cnt_c", 32'(ifc.pair_cnt), 0);
    check("clr_idle_in_ready", 32'(ifa.in_ready), 1);

    // five pairs through the 2-bit counter wrap
    @(posedge clk); #1;
    send_pairs(5, 8'h40);
    check("wrap_cnt_a", 32'(ifa.pair_cnt), 5);
    check("wrap_cnt_c", 32'(ifc.pair_cnt), 1);

    // asynchronous reset in the middle of a pair
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_d1    = 8'hA5;
    in_d2    = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_valid", 32'(ifa.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(ifa.out_valid), 0);
    check("arst_data_a", 32'(ifa.out_data), 0);
    check("arst_data_b", 32'(ifb.out_data), 0);
    check("arst_cnt", 32'(ifa.pair_cnt), 0);
    check("arst_in_ready", 32'(ifa.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("arst_rel_valid", 32'(ifa.out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("arst_rel_valid2", 32'(ifa.out_valid), 0);
    check("arst_rel_last", 32'(ifa.out_last), 0);
    check("arst_rel_cnt", 32'(ifa.pair_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
